branch_target_buffer: RTL and testbench
=======================================

# branch_target_buffer

Direct-mapped branch target buffer with 2-bit saturating direction counters, sitting directly upstream of the NPC generator in the IF stage. Each cycle it looks up the fetch PC and produces the predicted target and predict-taken flag consumed by the NPC generator. It is trained by conditional branches resolving in EX.

## Interface
- ENTRIES, 64, number of BTB entries; power of two, ≥2; IDX_W = log2(ENTRIES)
- clk  input  1  core clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- PC_IF  input  32  address of the instruction being fetched
- PC_pred_IF  output  32  predicted target; 0 when PC_pred_en_IF=0
- PC_pred_en_IF  output  1  predict taken for PC_IF
- br_inst_EX  input  1  EX stage holds a conditional branch
- br_EX  input  1  branch in EX resolved taken
- PC_br_EX  input  32  address of the branch in EX
- br_target  input  32  resolved target of the branch in EX
- bubbleE  input  1  EX stage stalled this cycle
- flushE  input  1  EX stage flushed this cycle
- PC_pred_en_EX  input  1  prediction carried with the EX branch (BTB_STATS_EN only)
- br_cnt  output  32  resolved-branch count (BTB_STATS_EN only)
- mispred_cnt  output  32  direction-mispredict count (BTB_STATS_EN only)

## Operation
- Address split: index = PC[IDX_W+1:2], tag = PC[31:IDX_W+2]; PC[1:0] ignored.
- Entry: valid, tag, 32-bit target, 2-bit counter (00 SNT, 01 WNT, 10 WT, 11 ST).
- Lookup (combinational): hit = valid && tag match; PC_pred_en_IF = hit && ctr[1]; PC_pred_IF = target if PC_pred_en_IF else 0.
- Update enable upd = br_inst_EX && !bubbleE && !flushE. No state changes when upd=0.
- upd, hit on PC_br_EX: ctr saturating +1 if br_EX else −1 (11 stays 11, 00 stays 00); if br_EX, target <= br_target.
- upd, miss, br_EX=1: allocate/replace: valid=1, tag, target=br_target, ctr=10.
- upd, miss, br_EX=0: no allocation, no change.
- Reset: all valid=0 (async); ctr reset to 01; target/tag need not reset. Reset mid-operation drops all entries immediately; PC_pred_en_IF=0 while rst_n=0.

## Timing
- Lookup latency 0: outputs settle in the same cycle as PC_IF.
- Update written on rising clk edge; visible to lookup from the following cycle.
- Same-cycle lookup and update of the same index: lookup returns pre-update contents (no bypass).
- Stall/flush of EX suppress the write for that cycle only; a branch held in EX across several bubbled cycles is written once, in the first unstalled cycle.

## Configuration
- BTB_STATS_EN defined: PC_pred_en_EX, br_cnt, mispred_cnt exist; on each upd br_cnt += 1, and mispred_cnt += 1 when br_EX != PC_pred_en_EX; both wrap at 2^32; both reset to 0.
- BTB_STATS_EN undefined: those three ports and counters are absent; prediction behaviour identical.

## Structure
- Shared package: counter state constants (SNT/WNT/WT/ST), counter alloc value WT, counter reset value WNT, default ENTRIES.
- One sub-module: bp_sat_ctr2 — combinational 2-bit saturating next-state (ctr, taken -> ctr_next).
- Storage as per-field register arrays; valid array on the async reset.

## Test plan
- After reset, PC_IF=0x0000_0040 -> PC_pred_en_IF=0, PC_pred_IF=0.
- upd taken PC_br_EX=0x40, br_target=0x100; next cycle PC_IF=0x40 -> en=1, PC_pred_IF=0x100; PC_IF=0x140 (same index at ENTRIES=64, different tag) -> en=0.
- Same branch resolved not-taken twice -> ctr 10->01->00; en=0 after first; then three taken -> 01, 10 (en=1), 11; a fourth taken stays 11.
- upd not-taken on miss PC_br_EX=0x80 -> no entry; PC_IF=0x80 -> en=0.
- upd with bubbleE=1 or flushE=1 -> no change to entry or stats counters; same-cycle lookup of updated index returns old value.
- BTB_STATS_EN: 5 branches, 2 with br_EX != PC_pred_en_EX -> br_cnt=5, mispred_cnt=2; rst_n low mid-run -> both 0, all entries invalid.

Source files
------------

// File: rtl/branch_target_buffer_pkg.sv
// Shared types and constants for the direct-mapped branch target buffer.
// Optional statistics counters are enabled with BTB_STATS_EN.
package branch_target_buffer_pkg;

  localparam int BTB_ENTRIES_DEFAULT = 64;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  localparam ctr_e CTR_ALLOC = CTR_WT;
  localparam ctr_e CTR_RESET = CTR_WNT;

endpackage

// File: rtl/branch_target_buffer_if.sv
// Fetch-lookup and EX-training signals of the branch target buffer.
// The statistics signals exist only when BTB_STATS_EN is defined.
interface branch_target_buffer_if;
  logic [31:0] PC_IF;
  logic [31:0] PC_pred_IF;
  logic        PC_pred_en_IF;
  logic        br_inst_EX;
  logic        br_EX;
  logic [31:0] PC_br_EX;
  logic [31:0] br_target;
  logic        bubbleE;
  logic        flushE;
`ifdef BTB_STATS_EN
  logic        PC_pred_en_EX;
  logic [31:0] br_cnt;
  logic [31:0] mispred_cnt;

  modport master (
    output PC_IF, br_inst_EX, br_EX, PC_br_EX, br_target, bubbleE, flushE, PC_pred_en_EX,
    input  PC_pred_IF, PC_pred_en_IF, br_cnt, mispred_cnt
  );
  modport slave (
    input  PC_IF, br_inst_EX, br_EX, PC_br_EX, br_target, bubbleE, flushE, PC_pred_en_EX,
    output PC_pred_IF, PC_pred_en_IF, br_cnt, mispred_cnt
  );
`else
  modport master (
    output PC_IF, br_inst_EX, br_EX, PC_br_EX, br_target, bubbleE, flushE,
    input  PC_pred_IF, PC_pred_en_IF
  );
  modport slave (
    input  PC_IF, br_inst_EX, br_EX, PC_br_EX, br_target, bubbleE, flushE,
    output PC_pred_IF, PC_pred_en_IF
  );
`endif
endinterface

// File: rtl/branch_target_buffer_bp_sat_ctr2.sv
// Combinational next-state of a 2-bit saturating direction counter.
module bp_sat_ctr2
  import branch_target_buffer_pkg::*;
(
  input  ctr_e ctr_i,
  input  logic taken_i,
  output ctr_e ctr_next_o
);

  always_comb begin
    // NOTE: default first so every path assigns the output and no latch is inferred.
    ctr_next_o = ctr_i;
    unique case (ctr_i)
      CTR_SNT: ctr_next_o = taken_i ? CTR_WNT : CTR_SNT;
      CTR_WNT: ctr_next_o = taken_i ? CTR_WT  : CTR_SNT;
      CTR_WT:  ctr_next_o = taken_i ? CTR_ST  : CTR_WNT;
      CTR_ST:  ctr_next_o = taken_i ? CTR_ST  : CTR_WT;
      default: ctr_next_o = ctr_i;
    endcase
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit direction counters: zero-latency lookup in IF,
// training from resolved conditional branches in EX. Stats under BTB_STATS_EN.
module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter int ENTRIES = BTB_ENTRIES_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  branch_target_buffer_if.slave  bus
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic [ENTRIES-1:0] valid_q;
  ctr_e               ctr_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];

  logic [IDX_W-1:0] idx_if, idx_ex;
  logic [TAG_W-1:0] tag_if, tag_ex;
  logic             hit_if, hit_ex, upd;
  ctr_e             ctr_d;

  assign idx_if = bus.PC_IF[IDX_W+1:2];
  assign tag_if = bus.PC_IF[31:IDX_W+2];
  assign idx_ex = bus.PC_br_EX[IDX_W+1:2];
  assign tag_ex = bus.PC_br_EX[31:IDX_W+2];

  // Byte offset within the word never participates in indexing or tagging.
  logic unused_byte_offset;
  assign unused_byte_offset = ^{bus.PC_IF[1:0], bus.PC_br_EX[1:0]};

  // Lookup reads the registered arrays only, so a same-cycle update is not bypassed.
  assign hit_if            = valid_q[idx_if] && (tag_q[idx_if] == tag_if);
  assign bus.PC_pred_en_IF = hit_if && ctr_q[idx_if][1];
  assign bus.PC_pred_IF    = bus.PC_pred_en_IF ? target_q[idx_if] : 32'h0;

  assign upd    = bus.br_inst_EX && !bus.bubbleE && !bus.flushE;
  assign hit_ex = valid_q[idx_ex] && (tag_q[idx_ex] == tag_ex);

  bp_sat_ctr2 u_sat_ctr (
    .ctr_i      (ctr_q[idx_ex]),
    .taken_i    (bus.br_EX),
    .ctr_next_o (ctr_d)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_RESET;
    end else if (upd) begin
      if (hit_ex) begin
        ctr_q[idx_ex] <= ctr_d;
      end else if (bus.br_EX) begin
        valid_q[idx_ex] <= 1'b1;
        ctr_q[idx_ex]   <= CTR_ALLOC;
      end
    end
  end

  // NOTE: tag/target are qualified by valid_q, so they are left without reset.
  always_ff @(posedge clk) begin
    if (upd && bus.br_EX) begin
      target_q[idx_ex] <= bus.br_target;
      if (!hit_ex) tag_q[idx_ex] <= tag_ex;
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] br_cnt_q, mispred_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
    end else if (upd) begin
      br_cnt_q <= br_cnt_q + 32'd1;
      if (bus.br_EX != bus.PC_pred_en_EX) mispred_cnt_q <= mispred_cnt_q + 32'd1;
    end
  end

  assign bus.br_cnt      = br_cnt_q;
  assign bus.mispred_cnt = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed self-checking bench for branch_target_buffer (ENTRIES=64).
// Statistics scenarios run only when BTB_STATS_EN is defined.
module tb_branch_target_buffer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  branch_target_buffer_if bus ();

  branch_target_buffer #(.ENTRIES(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one EX-stage branch for a single clock edge.
  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                     input logic bub, input logic fl, input logic pe);
    @(negedge clk);
    bus.br_inst_EX = 1'b1;
    bus.PC_br_EX   = pc;
    bus.br_EX      = tk;
    bus.br_target  = tgt;
    bus.bubbleE    = bub;
    bus.flushE     = fl;
`ifdef BTB_STATS_EN
    bus.PC_pred_en_EX = pe;
`else
    if (pe) bus.br_target = tgt;
`endif
    @(posedge clk);
    #1;
    bus.br_inst_EX = 1'b0;
    bus.bubbleE    = 1'b0;
    bus.flushE     = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc);
    bus.PC_IF = pc;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.PC_IF = 32'h40;
    bus.br_inst_EX = 1'b0;
    bus.br_EX = 1'b0;
    bus.PC_br_EX = '0;
    bus.br_target = '0;
    bus.bubbleE = 1'b0;
    bus.flushE = 1'b0;
`ifdef BTB_STATS_EN
    bus.PC_pred_en_EX = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.PC_pred_en_IF !== 1'b0) begin errors++; $display("FAIL rst_en_low: got %b want 0", bus.PC_pred_en_IF); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    look(32'h40);
    checks++;
    if (bus.PC_pred_en_IF !== 1'b0) begin errors++; $display("FAIL rst_en: got %b want 0", bus.PC_pred_en_IF); end
    checks++;
    if (bus.PC_pred_IF !== 32'h0) begin errors++; $display("FAIL rst_pred: got %h want 0", bus.PC_pred_IF); end
  endtask

  task automatic test_alloc();
    upd(32'h40, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
    look(32'h40);
    checks++;
    if (bus.PC_pred_en_IF !== 1'b1) begin errors++; $display("FAIL alloc_en: got %b want 1", bus.PC_pred_en_IF); end
    checks++;
    if (bus.PC_pred_IF !== 32'h100) begin errors++; $display("FAIL alloc_pred: got %h want 100", bus.PC_pred_IF); end
    look(32'h140);
    checks++;
    if (bus.PC_pred_en_IF !== 1'b0) begin errors++; $display("FAIL alias_en: got %b want 0", bus.PC_pred_en_IF); end
    checks++;
    if (bus.PC_pred_IF !== 32'h0) begin errors++; $display("FAIL alias_pred: got %h want 0", bus.PC_pred_IF); end
    look(32'h42);
    checks++;
    if (bus.PC_pred_en_IF !== 1'b1) begin errors++; $display("FAIL byte_off_en: got %b want 1", bus.PC_pred_en_IF); end
  endtask

  // Counter walk on PC 0x40, starting from WT after allocation.
  task automatic test_counter();
    logic        tk_seq  [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] tgt_seq [7] = '{32'h0, 32'h0, 32'h180, 32'h180, 32'h1c0, 32'h200, 32'h0};
    logic        en_exp  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [31:0] pr_exp  [7] = '{32'h0, 32'h0, 32'h0, 32'h180, 32'h1c0, 32'h200, 32'h200};
    for (int i = 0; i < 7; i++) begin
      upd(32'h40, tk_seq[i], tgt_seq[i], 1'b0, 1'b0, 1'b0);
      look(32'h40);
      checks++;
      if (bus.PC_pred_en_IF !== en_exp[i]) begin
        errors++; $display("FAIL ctr_en[%0d]: got %b want %b", i, bus.PC_pred_en_IF, en_exp[i]);
      end
      checks++;
      if (bus.PC_pred_IF !== pr_exp[i]) begin
        errors++; $display("FAIL ctr_pred[%0d]: got %h want %h", i, bus.PC_pred_IF, pr_exp[i]);
      end
    end
  endtask

  task automatic test_no_alloc();
    upd(32'h80, 1'b0, 32'h999, 1'b0, 1'b0, 1'b0);
    look(32'h80);
    checks++;
    if (bus.PC_pred_en_IF !== 1'b0) begin errors++; $display("FAIL no_alloc_en: got %b want 0", bus.PC_pred_en_IF); end
  endtask

  task automatic test_stall_flush();
    upd(32'h80, 1'b1, 32'h300, 1'b1, 1'b0, 1'b0);
    look(32'h80);
    checks++;
    if (bus.PC_pred_en_IF !== 1'b0) begin errors++; $display("FAIL bubble_alloc_en: got %b want 0", bus.PC_pred_en_IF); end
    upd(32'h80, 1'b1, 32'h300, 1'b0, 1'b1, 1'b0);
    look(32'h80);
    checks++;
    if (bus.PC_pred_en_IF !== 1'b0) begin errors++; $display("FAIL flush_alloc_en: got %b want 0", bus.PC_pred_en_IF); end
    // Entry 0x40 is WT with target 0x200; suppressed updates must leave it.
    upd(32'h40, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    upd(32'h40, 1'b1, 32'h444, 1'b0, 1'b1, 1'b0);
    look(32'h40);
    checks++;
    if (bus.PC_pred_en_IF !== 1'b1) begin errors++; $display("FAIL stall_keep_en: got %b want 1", bus.PC_pred_en_IF); end
    checks++;
    if (bus.PC_pred_IF !== 32'h200) begin errors++; $display("FAIL stall_keep_pred: got %h want 200", bus.PC_pred_IF); end
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    bus.br_inst_EX = 1'b1;
    bus.PC_br_EX   = 32'h80;
    bus.br_EX      = 1'b1;
    bus.br_target  = 32'h300;
    bus.PC_IF      = 32'h80;
    #1;
    checks++;
    if (bus.PC_pred_en_IF !== 1'b0) begin errors++; $display("FAIL same_cycle_old_en: got %b want 0", bus.PC_pred_en_IF); end
    @(posedge clk);
    #1;
    bus.br_inst_EX = 1'b0;
    #1;
    checks++;
    if (bus.PC_pred_en_IF !== 1'b1) begin errors++; $display("FAIL same_cycle_new_en: got %b want 1", bus.PC_pred_en_IF); end
    checks++;
    if (bus.PC_pred_IF !== 32'h300) begin errors++; $display("FAIL same_cycle_new_pred: got %h want 300", bus.PC_pred_IF); end
  endtask

`ifdef BTB_STATS_EN
  task automatic test_stats();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    upd(32'h400, 1'b1, 32'h500, 1'b0, 1'b0, 1'b0);
    upd(32'h400, 1'b1, 32'h500, 1'b0, 1'b0, 1'b1);
    upd(32'h400, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1);
    upd(32'h404, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0);
    upd(32'h404, 1'b1, 32'h600, 1'b1, 1'b0, 1'b0);
    upd(32'h404, 1'b1, 32'h600, 1'b0, 1'b1, 1'b0);
    upd(32'h400, 1'b1, 32'h500, 1'b0, 1'b0, 1'b1);
    checks++;
    if (bus.br_cnt !== 32'd5) begin errors++; $display("FAIL stats_br_cnt: got %0d want 5", bus.br_cnt); end
    checks++;
    if (bus.mispred_cnt !== 32'd2) begin errors++; $display("FAIL stats_mispred_cnt: got %0d want 2", bus.mispred_cnt); end
  endtask
`endif

  task automatic test_reset_mid();
    upd(32'h40, 1'b1, 32'h700, 1'b0, 1'b0, 1'b0);
    look(32'h40);
    checks++;
    if (bus.PC_pred_en_IF !== 1'b1) begin errors++; $display("FAIL pre_reset_en: got %b want 1", bus.PC_pred_en_IF); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.PC_pred_en_IF !== 1'b0) begin errors++; $display("FAIL async_reset_en: got %b want 0", bus.PC_pred_en_IF); end
`ifdef BTB_STATS_EN
    checks++;
    if (bus.br_cnt !== 32'd0) begin errors++; $display("FAIL reset_br_cnt: got %0d want 0", bus.br_cnt); end
    checks++;
    if (bus.mispred_cnt !== 32'd0) begin errors++; $display("FAIL reset_mispred_cnt: got %0d want 0", bus.mispred_cnt); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    look(32'h40);
    checks++;
    if (bus.PC_pred_en_IF !== 1'b0) begin errors++; $display("FAIL post_reset_en: got %b want 0", bus.PC_pred_en_IF); end
    look(32'h80);
    checks++;
    if (bus.PC_pred_en_IF !== 1'b0) begin errors++; $display("FAIL post_reset_en_80: got %b want 0", bus.PC_pred_en_IF); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_alloc();
    test_counter();
    test_no_alloc();
    test_stall_flush();
    test_same_cycle();
`ifdef BTB_STATS_EN
    test_stats();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
